stp_receiver: RTL and testbench
===============================

# stp_receiver

Serial-to-parallel receiver for the SPI module, the receive-side counterpart of the parallel-to-serial transmit path. It assembles DATA_WIDTH bits arriving MSB first on the MRAM serial data-out line into a parallel word. Bits are captured one per sample strobe issued by the SPI controller, and the completed word is presented with a valid/acknowledge handshake. It sits between the SPI pin interface and the FPGA-side read-data consumer.

## Interface
- DATA_WIDTH, 16, number of bits per received word (2..32)
- FPGA_clk  input  1  system clock; all logic on rising edge
- FPGA_rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that arms reception of one word
- abort  input  1  discards any partial word and returns to idle
- sample_stb  input  1  one-cycle pulse from the SPI controller at each SCK sampling edge
- ser_data_in  input  1  serial data from the device (MISO)
- data_out  output  DATA_WIDTH  last completed word, held until the next completion
- data_valid  output  1  high from word completion until acknowledged
- data_ack  input  1  consumer acknowledge; clears data_valid
- busy  output  1  high while in RECV
- overrun  output  1  sticky error flag; present only with STP_OVERRUN_EN

## Operation
- States: IDLE, RECV.
- IDLE:
  - start=1 -> RECV.
  - Bit counter cnt loads DATA_WIDTH-1.
  - Shift buffer clears to 0.
  - sample_stb is ignored in IDLE, including in the same cycle as start.
- RECV, when sample_stb=1:
  - buf[cnt] <= ser_data_in, so the first bit lands at the MSB.
  - If cnt>0, decrement cnt.
  - If cnt==0, this is the final bit. On the next edge, data_out <= completed word (including this bit), data_valid <= 1, and the state returns to IDLE.
- RECV, when sample_stb=0: hold state.
- start is ignored while in RECV.
- abort=1 in RECV -> IDLE on the next edge. The partial word is discarded; data_out and data_valid are unchanged.
- abort has priority over sample_stb in the same cycle.
- abort in IDLE has no effect, and start is ignored in a cycle where abort=1.
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid on the next edge.
  - data_ack while data_valid=0 is ignored.
- Word completion and data_ack in the same cycle: completion wins. data_out updates, data_valid stays 1, and there is no overrun.
- data_out changes only at completion and is stable while data_valid=1, unless an overrun occurs (see Configuration).

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, state=IDLE, cnt=DATA_WIDTH-1, buffer=0.
- Reset mid-word discards everything.
- start at edge N -> busy=1 after edge N.
- Final sample_stb at cycle M -> data_valid=1 and data_out valid after edge M, and busy=0 after the same edge.
- Latency from the last strobe to valid is 1 clock.
- Minimum strobe spacing is 1 clock; back-to-back strobes on consecutive cycles are legal.
- A new start may be issued in the cycle after busy falls; the previous word must be acknowledged first to avoid overrun.

## Configuration
- Macro: STP_OVERRUN_EN.
- Defined:
  - overrun port exists.
  - If a word completes while data_valid=1 and data_ack=0, data_out is overwritten and overrun is set to 1.
  - overrun stays set until FPGA_rst.
- Undefined:
  - No overrun port and no flag logic.
  - A completion while data_valid=1 silently overwrites data_out, and data_valid stays 1.

## Test plan
- Reset, then start, then 16 strobes carrying 0xA5C3 MSB first -> after the 16th strobe + 1 clock: data_out=0xA5C3, data_valid=1, busy=0. Then data_ack -> data_valid=0 next clock, data_out still 0xA5C3.
- start, 16 strobes spaced 1 clock apart carrying 0xFFFF, then 0x0001 in a second word -> data_out=0xFFFF, then 0x0001, with no bit bleed from the first word.
- start, 7 strobes of 1, then abort, then start and 16 strobes of 0x1234 -> only 0x1234 appears; no valid after the abort.
- Strobes in IDLE with ser_data_in=1 and no start -> data_valid never asserts, data_out stays 0. FPGA_rst asserted after 8 bits of a word -> all outputs 0 and state IDLE.
- Second word 0xBEEF completes with 0x1111 unacknowledged. With STP_OVERRUN_EN: data_out=0xBEEF, overrun=1, cleared only by reset. Without it: data_out=0xBEEF, data_valid=1.
- data_ack pulsed in the same cycle as the final strobe of 0x5A5A -> data_valid remains 1 with data_out=0x5A5A, and overrun=0.

Source files
------------

// File: rtl/stp_receiver.sv
// stp_receiver: serial-to-parallel receive path of the SPI module.
// Assembles DATA_WIDTH bits arriving MSB first on the device data-out line,
// one bit per controller sample strobe, and presents the completed word to the
// FPGA-side consumer with a valid/acknowledge handshake.
//
// Optional feature: define STP_OVERRUN_EN to add the sticky 'overrun' output,
// which flags a word completing on top of an unacknowledged one.

module stp_receiver #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  FPGA_clk,
  input  logic                  FPGA_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sample_stb,
  input  logic                  ser_data_in,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
`ifdef STP_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  // Counter wide enough to hold DATA_WIDTH-1 (the MSB bit index).
  localparam int unsigned          CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    word_done;   // final bit of a word captured this cycle

  // Next-state logic: bit counter, shift buffer and IDLE/RECV sequencing.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Keep the datapath primed so a word always starts from a clean buffer.
        cnt_d   = CNT_LAST;
        shift_d = '0;
        // A strobe in the same cycle as start is deliberately not captured.
        if (start && !abort) begin
          state_d = RECV;
        end
      end

      RECV: begin
        if (abort) begin
          // Abort wins over a simultaneous strobe; the partial word is dropped.
          state_d = IDLE;
          cnt_d   = CNT_LAST;
          shift_d = '0;
        end else if (sample_stb) begin
          // Bit lands at index cnt, so the first bit received is the MSB.
          shift_d[cnt_q] = ser_data_in;
          if (cnt_q == '0) begin
            word_done = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output word and handshake: completion always beats a same-cycle acknowledge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (word_done) begin
      data_d  = shift_d;
      valid_d = 1'b1;
    end else if (data_ack) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge FPGA_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (FPGA_rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_LAST;
      // NOTE: the shift buffer is reset along with the control state so that
      // a word interrupted by reset can never leak bits into the next word.
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef STP_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a word completed while the previous one was still pending.
  always_comb begin
    overrun_d = overrun_q | (word_done & valid_q & ~data_ack);
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == RECV);

endmodule

// File: tb/tb_stp_receiver.sv
// tb_stp_receiver: directed, self-checking bench for stp_receiver
// (DATA_WIDTH = 16). A vector table covers single-cycle control corners;
// hand-written sequences cover whole-word reception, handshake and overrun.

module tb_stp_receiver;

  localparam int unsigned DW = 16;

  logic          FPGA_clk;
  logic          FPGA_rst;
  logic          start;
  logic          abort;
  logic          sample_stb;
  logic          ser_data_in;
  logic          data_ack;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
`ifdef STP_OVERRUN_EN
  logic          overrun;
`endif

  int checks = 0;
  int errors = 0;

  stp_receiver #(.DATA_WIDTH(DW)) dut (
    .FPGA_clk    (FPGA_clk),
    .FPGA_rst    (FPGA_rst),
    .start       (start),
    .abort       (abort),
    .sample_stb  (sample_stb),
    .ser_data_in (ser_data_in),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy)
`ifdef STP_OVERRUN_EN
    ,
    .overrun     (overrun)
`endif
  );

  initial FPGA_clk = 1'b0;
  always #5 FPGA_clk = ~FPGA_clk;

  typedef struct {
    string       name;
    logic        st;
    logic        ab;
    logic        stb;
    logic        din;
    logic        ack;
    logic        exp_busy;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then return 1 ns after it.
  task automatic step(input logic st, input logic ab, input logic stb,
                      input logic din, input logic ack);
    start       = st;
    abort       = ab;
    sample_stb  = stb;
    ser_data_in = din;
    data_ack    = ack;
    @(posedge FPGA_clk);
    #1;
    start       = 1'b0;
    abort       = 1'b0;
    sample_stb  = 1'b0;
    ser_data_in = 1'b0;
    data_ack    = 1'b0;
  endtask

  // Receive one word MSB first; 'gap' idle cycles between strobes, optional
  // ack on the final strobe, optional (ignored) strobe in the start cycle.
  // Mid-word, the previously completed word must still be on data_out.
  task automatic recv_word(input logic [15:0] w, input int gap, input bit ack_last,
                           input bit stb_on_start, input logic [15:0] prev);
    step(1'b1, 1'b0, stb_on_start, 1'b1, 1'b0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, w[i], (ack_last && i == 0));
      if (i == 8) begin
        check("data_held_mid_word", {16'd0, data_out}, {16'd0, prev});
      end
      if (i != 0) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] exp);
    check({name, "_data"},  {16'd0, data_out},   {16'd0, exp});
    check({name, "_valid"}, {31'd0, data_valid}, 32'd1);
    check({name, "_busy"},  {31'd0, busy},       32'd0);
  endtask

  task automatic ack_word(input string name, input logic [15:0] exp);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check({name, "_ack_valid"}, {31'd0, data_valid}, 32'd0);
    check({name, "_ack_data"},  {16'd0, data_out},   {16'd0, exp});
  endtask

  initial begin
    //            name                st ab stb din ack busy valid data
    vecs[0]  = '{"idle_strobe",       0, 0, 1,  1,  0,  0,   0,    16'h0000};
    vecs[1]  = '{"idle_ack",          0, 0, 0,  0,  1,  0,   0,    16'h0000};
    vecs[2]  = '{"idle_abort",        0, 1, 0,  0,  0,  0,   0,    16'h0000};
    vecs[3]  = '{"start_with_abort",  1, 1, 0,  0,  0,  0,   0,    16'h0000};
    vecs[4]  = '{"start_with_strobe", 1, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[5]  = '{"partial_bit1",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[6]  = '{"partial_bit2",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[7]  = '{"partial_bit3",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[8]  = '{"partial_bit4",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[9]  = '{"partial_bit5",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[10] = '{"partial_bit6",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[11] = '{"partial_bit7",      0, 0, 1,  1,  0,  1,   0,    16'h0000};
    vecs[12] = '{"restart_ignored",   1, 0, 0,  0,  0,  1,   0,    16'h0000};
    vecs[13] = '{"abort_over_strobe", 0, 1, 1,  1,  0,  0,   0,    16'h0000};
    vecs[14] = '{"after_abort",       0, 0, 0,  0,  0,  0,   0,    16'h0000};

    FPGA_rst    = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    sample_stb  = 1'b0;
    ser_data_in = 1'b0;
    data_ack    = 1'b0;
    repeat (2) @(posedge FPGA_clk);
    #1;
    check("reset_data",  {16'd0, data_out},   32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_busy",  {31'd0, busy},       32'd0);
`ifdef STP_OVERRUN_EN
    check("reset_overrun", {31'd0, overrun}, 32'd0);
`endif
    FPGA_rst = 1'b0;

    // Single-cycle control corners, including 7 bits then abort.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].st, vecs[i].ab, vecs[i].stb, vecs[i].din, vecs[i].ack);
      check({vecs[i].name, "_busy"},  {31'd0, busy},       {31'd0, vecs[i].exp_busy});
      check({vecs[i].name, "_valid"}, {31'd0, data_valid}, {31'd0, vecs[i].exp_valid});
      check({vecs[i].name, "_data"},  {16'd0, data_out},   {16'd0, vecs[i].exp_data});
    end

    // After the aborted word: only 0x1234 appears (strobe in start cycle ignored).
    recv_word(16'h1234, 0, 1'b0, 1'b1, 16'h0000);
    check_word("w1234", 16'h1234);
    ack_word("w1234", 16'h1234);

    recv_word(16'hA5C3, 0, 1'b0, 1'b0, 16'h1234);
    check_word("wA5C3", 16'hA5C3);
    ack_word("wA5C3", 16'hA5C3);

    // Spaced strobes, then a back-to-back word: no bleed between words.
    recv_word(16'hFFFF, 1, 1'b0, 1'b0, 16'hA5C3);
    check_word("wFFFF", 16'hFFFF);
    ack_word("wFFFF", 16'hFFFF);
    recv_word(16'h0001, 0, 1'b0, 1'b0, 16'hFFFF);
    check_word("w0001", 16'h0001);
    ack_word("w0001", 16'h0001);

    // Reset after 8 bits of a word discards everything.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    FPGA_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    FPGA_rst = 1'b0;
    check("midreset_data",  {16'd0, data_out},   32'd0);
    check("midreset_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_busy",  {31'd0, busy},       32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_strobes_valid", {31'd0, data_valid}, 32'd0);
    check("idle_strobes_data",  {16'd0, data_out},   32'd0);
    recv_word(16'h8001, 0, 1'b0, 1'b0, 16'h0000);
    check_word("w8001", 16'h8001);
    ack_word("w8001", 16'h8001);

    // Completion on top of an unacknowledged word.
    recv_word(16'h1111, 0, 1'b0, 1'b0, 16'h8001);
    check_word("w1111", 16'h1111);
    recv_word(16'hBEEF, 0, 1'b0, 1'b0, 16'h1111);
    check_word("wBEEF", 16'hBEEF);
`ifdef STP_OVERRUN_EN
    check("overrun_set", {31'd0, overrun}, 32'd1);
`endif
    ack_word("wBEEF", 16'hBEEF);
`ifdef STP_OVERRUN_EN
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
`endif

    // Reset clears overrun; then ack coinciding with completion.
    FPGA_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    FPGA_rst = 1'b0;
    check("rst2_data", {16'd0, data_out}, 32'd0);
`ifdef STP_OVERRUN_EN
    check("rst2_overrun", {31'd0, overrun}, 32'd0);
`endif
    recv_word(16'h3C3C, 0, 1'b0, 1'b0, 16'h0000);
    check_word("w3C3C", 16'h3C3C);
    recv_word(16'h5A5A, 0, 1'b1, 1'b0, 16'h3C3C);
    check_word("w5A5A", 16'h5A5A);
`ifdef STP_OVERRUN_EN
    check("ack_race_overrun", {31'd0, overrun}, 32'd0);
`endif
    ack_word("w5A5A", 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
